// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled frame recovery with parity/stop checks
// and a single-entry holding register read back via rx_read_i.
//
// Ports: clk, rst_n (sync, active low), rx_tick (oversample strobe),
//   rx (async serial in), data_bit_num_i/parity_en_i/parity_type_i/
//   stop_bit_num_i (frame format), rx_read_i (consume strobe),
//   rx_data_o, rx_valid_o, rx_done_o, parity_err_o, frame_err_o,
//   overrun_o, rts_n.
// Option: define UART_RX_RTS_EN to drive rts_n from the holding-register
//   full flag; otherwise rts_n is tied low.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_tick,
  input  logic       rx,
  input  logic [1:0] data_bit_num_i,
  input  logic       parity_en_i,
  input  logic       parity_type_i,
  input  logic       stop_bit_num_i,
  input  logic       rx_read_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_done_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       rts_n
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t state, state_n;

  logic          rx_m, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [2:0]    last_bit;
  logic [7:0]    shreg;
  logic          par_en, par_odd, two_stop;
  logic          perr, ferr;
  logic          fall, mid, complete;

  // Edge only, so a held-low line (break) cannot retrigger.
  assign fall = rx_d & ~rx_s;

  // Start is checked half a bit in; every later sample a full bit on.
  always_comb begin
    mid = rx_tick &&
          (cnt == ((state == START) ? HALF_M1 : FULL_M1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    complete = 1'b0;
    case (state)
      IDLE:   if (fall) state_n = START;
      START:  if (mid) state_n = rx_s ? IDLE : DATA;
      DATA:   if (mid && idx == last_bit)
                state_n = par_en ? PARITY : STOP;
      PARITY: if (mid) state_n = STOP;
      STOP:   if (mid && idx[0] == two_stop) begin
                state_n  = IDLE;
                complete = 1'b1;
              end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      rx_d         <= 1'b1;
      cnt          <= '0;
      idx          <= '0;
      last_bit     <= '0;
      shreg        <= '0;
      par_en       <= 1'b0;
      par_odd      <= 1'b0;
      two_stop     <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_done_o    <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_d      <= rx_s;
      rx_done_o <= complete;
      if (rx_tick) cnt <= cnt + CW'(1);
      case (state)
        IDLE: if (fall) begin
          cnt      <= '0;
          idx      <= '0;
          shreg    <= '0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
          last_bit <= {1'b1, data_bit_num_i};
          par_en   <= parity_en_i;
          par_odd  <= parity_type_i;
          two_stop <= stop_bit_num_i;
        end
        START: if (mid) begin
          cnt <= '0;
          idx <= '0;
        end
        DATA: if (mid) begin
          shreg[idx] <= rx_s;
          idx <= (idx == last_bit) ? 3'd0 : idx + 3'd1;
        end
        PARITY: if (mid) perr <= rx_s != (^shreg ^ par_odd);
        STOP: if (mid) begin
          ferr <= ferr | ~rx_s;
          idx  <= idx + 3'd1;
        end
        default: ;
      endcase
      if (complete) begin
        if (!rx_valid_o || rx_read_i) begin
          rx_data_o    <= shreg;
          parity_err_o <= perr;
          frame_err_o  <= ferr | ~rx_s;
          rx_valid_o   <= 1'b1;
          overrun_o    <= 1'b0;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_read_i && rx_valid_o) begin
        rx_valid_o <= 1'b0;
        overrun_o  <= 1'b0;
      end
    end
  end

`ifdef UART_RX_RTS_EN
  assign rts_n = rx_valid_o;
`else
  assign rts_n = 1'b0;
`endif

endmodule
